// File: rtl/sprite_pkg.sv
// Shared constants and FSM encoding for the sprite blitter and its helpers.
package sprite_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SPR_W      = 32;
  localparam int SPR_H      = 32;
  localparam int N_SPR      = 4;
  localparam int COLOUR_W   = 3;
  localparam int KEY_COLOUR = 0;
  localparam int BG_COLOUR  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Blit request/status handshake between the game control FSM and the blitter.
interface sprite_blitter_if
  import sprite_pkg::*;
#(
  parameter int N_SPR_P = N_SPR,
  localparam int SW     = width_of(N_SPR_P)
) ();

  logic          start;
  logic          erase;
  logic [SW-1:0] sel;
  logic [7:0]    x0;
  logic [6:0]    y0;
  logic          busy;
  logic          done;

  modport master (output start, erase, sel, x0, y0, input busy, done);
  modport slave  (input start, erase, sel, x0, y0, output busy, done);

endinterface

// File: rtl/sprite_raster_counter.sv
// Column/row raster walker over a W x H rectangle with wrap and last-pixel flag.
module sprite_raster_counter
  import sprite_pkg::*;
#(
  parameter int W        = SPR_W,
  parameter int H        = SPR_H,
  localparam int CW      = width_of(W),
  localparam int RW      = width_of(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] next_col,
  output logic [RW-1:0] next_row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  // NOTE: defaulting every output first keeps this block purely combinational (no latch).
  always_comb begin
    next_col = col;
    next_row = row;
    if (clear) begin
      next_col = '0;
      next_row = '0;
    end else if (step) begin
      if (col == COL_MAX) begin
        next_col = '0;
        next_row = (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        next_col = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= next_col;
      row <= next_row;
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// Blits one ROM sprite into the framebuffer with colour keying, edge clipping and erase.
module sprite_blitter #(
  parameter int SCREEN_W   = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H   = sprite_pkg::SCREEN_H,
  parameter int SPR_W      = sprite_pkg::SPR_W,
  parameter int SPR_H      = sprite_pkg::SPR_H,
  parameter int N_SPR      = sprite_pkg::N_SPR,
  parameter int COLOUR_W   = sprite_pkg::COLOUR_W,
  parameter int KEY_COLOUR = sprite_pkg::KEY_COLOUR,
  parameter int BG_COLOUR  = sprite_pkg::BG_COLOUR,
  localparam int SW        = sprite_pkg::width_of(N_SPR),
  localparam int AW        = $clog2(N_SPR * SPR_W * SPR_H)
) (
  input  logic                clk,
  input  logic                reset,
  sprite_blitter_if.slave     ctrl,
  output logic [AW-1:0]       rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  import sprite_pkg::*;

  localparam int P  = SPR_W * SPR_H;
  localparam int CW = width_of(SPR_W);
  localparam int RW = width_of(SPR_H);

  localparam logic [8:0]          X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0]          Y_LIMIT = 8'(SCREEN_H);
  localparam logic [COLOUR_W-1:0] KEY     = COLOUR_W'(KEY_COLOUR);
  localparam logic [COLOUR_W-1:0] BG      = COLOUR_W'(BG_COLOUR);

  state_t        state;
  logic          flush_cnt;
  logic [SW-1:0] sel_q;
  logic [7:0]    x0_q;
  logic [6:0]    y0_q;
  logic          erase_q;

  logic [CW-1:0] col, next_col;
  logic [RW-1:0] row, next_row;
  logic          last_pix;

  logic          accept;
  logic          drawing;
  logic [SW-1:0] sel_next;
  logic [AW-1:0] addr_next;

  logic          v1;
  logic [8:0]    px1;
  logic [7:0]    py1;

  assign accept  = (state == IDLE) && ctrl.start;
  assign drawing = (state == DRAW);

  sprite_raster_counter #(.W(SPR_W), .H(SPR_H)) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .step     (drawing),
    .col      (col),
    .row      (row),
    .next_col (next_col),
    .next_row (next_row),
    .last     (last_pix)
  );

  // The address register tracks the counter, so the first address uses the live sel.
  assign sel_next  = accept ? ctrl.sel : sel_q;
  assign addr_next = AW'(int'(sel_next) * P + int'(next_row) * SPR_W + int'(next_col));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      sel_q     <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      erase_q   <= 1'b0;
      rom_addr  <= '0;
      ctrl.busy <= 1'b0;
      ctrl.done <= 1'b0;
    end else begin
      ctrl.done <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl.start) begin
            sel_q     <= ctrl.sel;
            x0_q      <= ctrl.x0;
            y0_q      <= ctrl.y0;
            erase_q   <= ctrl.erase;
            rom_addr  <= addr_next;
            ctrl.busy <= 1'b1;
            state     <= DRAW;
          end
        end
        DRAW: begin
          if (last_pix) begin
            rom_addr  <= '0;
            flush_cnt <= 1'b0;
            state     <= FLUSH;
          end else begin
            rom_addr <= addr_next;
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            ctrl.busy <= 1'b0;
            ctrl.done <= 1'b1;
            state     <= IDLE;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        default: begin
          ctrl.busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Side-band stage 1 lines up with the ROM read; the output stage applies clip and key.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      px1        <= '0;
      py1        <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      v1         <= drawing;
      px1        <= {1'b0, x0_q} + 9'(col);
      py1        <= {1'b0, y0_q} + 8'(row);
      vga_plot   <= v1 && (px1 < X_LIMIT) && (py1 < Y_LIMIT) && (erase_q || (rom_data != KEY));
      vga_colour <= erase_q ? BG : rom_data;
      vga_x      <= px1[7:0];
      vga_y      <= py1[6:0];
    end
  end

endmodule
